// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle ARM core multiply/divide unit:
// op encodings, FSM state encoding, completion kinds and flag bit indices.
package mc_pkg;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULL = 3'b001;
  localparam logic [2:0] OP_SMULL = 3'b010;
  localparam logic [2:0] OP_UDIV  = 3'b100;
  localparam logic [2:0] OP_SDIV  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // How FIX should build its result: normal iteration, divide by zero, or illegal op.
  typedef enum logic [1:0] {
    K_NORM = 2'b00,
    K_DIV0 = 2'b01,
    K_ILL  = 2'b10
  } kind_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Ops whose operands are two's complement and get magnitude-converted at launch.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_SMULL) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/mc_muldiv_step.sv
// One combinational radix-2 step. Multiply mode: shift-add with the
// multiplier consumed from q's lsb and product bits entering q's msb.
// Divide mode: restoring shift-subtract with the dividend leaving q's msb
// and quotient bits entering q's lsb. d_i is the multiplicand or divisor.
module mc_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;

  // Single shift-add or restoring shift-subtract step.
  always_comb begin
    sum_s   = {(WIDTH+1){1'b0}};
    trial_s = {(WIDTH+1){1'b0}};
    diff_s  = {(WIDTH+1){1'b0}};
    acc_o   = acc_i;
    q_o     = q_i;
    if (div_mode) begin
      // Remainder stays below the divisor, so trial - divisor fits in WIDTH+1 bits.
      trial_s = {acc_i, q_i[WIDTH-1]};
      diff_s  = trial_s - {1'b0, d_i};
      if (!diff_s[WIDTH]) begin
        acc_o = diff_s[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = trial_s[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (q_i[0]) begin
        sum_s = {1'b0, acc_i} + {1'b0, d_i};
      end else begin
        sum_s = {1'b0, acc_i};
      end
      acc_o = sum_s[WIDTH:1];
      q_o   = {sum_s[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mc_muldiv_unit.sv
// Iterative multiply/divide execute unit (MUL, UMULL, SMULL, UDIV, SDIV).
// Operands are magnitude-converted at launch, iterated UNROLL steps per
// cycle in CALC, and sign-corrected in FIX.
// Optional: define MULDIV_EARLY_TERM_EN to leave CALC early on multiplies
// once the remaining multiplier bits are all zero.
module mc_muldiv_unit
  import mc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             dbz_q, dbz_d;
`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] mrem_q, mrem_d;
`endif

  logic             sa_s, sb_s, long_s;
  logic [WIDTH-1:0] a_abs_s, b_abs_s, res_lo_s, res_hi_s;
  logic [2*WIDTH-1:0] prod_s, prod_neg_s;

  logic [WIDTH-1:0] ch_acc [UNROLL+1];
  logic [WIDTH-1:0] ch_q   [UNROLL+1];

  assign ch_acc[0] = acc_q;
  assign ch_q[0]   = q_q;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
    mc_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (op_q[2]),
      .acc_i    (ch_acc[gi]),
      .q_i      (ch_q[gi]),
      .d_i      (dv_q),
      .acc_o    (ch_acc[gi+1]),
      .q_o      (ch_q[gi+1])
    );
  end

  // Raw product, realigned when the multiply left CALC before all steps ran.
  always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
    prod_s = {acc_q, q_q} >> (WIDTH - int'(cnt_q) * UNROLL);
`else
    prod_s = {acc_q, q_q};
`endif
    if (qneg_q) begin
      prod_neg_s = {(2*WIDTH){1'b0}} - prod_s;
    end else begin
      prod_neg_s = prod_s;
    end
  end

  // Next-state, datapath and result/flag computation.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    op_d     = op_q;
    acc_d    = acc_q;
    q_d      = q_q;
    dv_d     = dv_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ovf_d    = ovf_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    res_lo_s = ZERO_W;
    res_hi_s = ZERO_W;
    long_s   = 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
    mrem_d   = mrem_q;
`endif
    sa_s     = a[WIDTH-1] & is_signed_op(op);
    sb_s     = b[WIDTH-1] & is_signed_op(op);
    a_abs_s  = sa_s ? (ZERO_W - a) : a;
    b_abs_s  = sb_s ? (ZERO_W - b) : b;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          cnt_d  = {CW{1'b0}};
          acc_d  = ZERO_W;
          kind_d = K_NORM;
          qneg_d = sa_s ^ sb_s;
          rneg_d = sa_s;
          ovf_d  = 1'b0;
          case (op)
            OP_MUL, OP_UMULL, OP_SMULL: begin
              q_d     = b_abs_s;
              dv_d    = a_abs_s;
              state_d = S_CALC;
`ifdef MULDIV_EARLY_TERM_EN
              mrem_d  = b_abs_s;
              if (b_abs_s == ZERO_W) begin
                state_d = S_FIX;
              end else begin
                state_d = S_CALC;
              end
`endif
            end
            OP_UDIV, OP_SDIV: begin
              if (b == ZERO_W) begin
                // Keep the raw dividend; it is reported as the remainder.
                kind_d  = K_DIV0;
                q_d     = a;
                state_d = S_FIX;
              end else begin
                q_d     = a_abs_s;
                dv_d    = b_abs_s;
                ovf_d   = (op == OP_SDIV) && (a == MIN_W) && (b == ONES_W);
                state_d = S_CALC;
              end
            end
            default: begin
              kind_d  = K_ILL;
              state_d = S_FIX;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        acc_d = ch_acc[UNROLL];
        q_d   = ch_q[UNROLL];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
`ifdef MULDIV_EARLY_TERM_EN
        mrem_d = mrem_q >> UNROLL;
        if (!op_q[2] && (mrem_d == ZERO_W)) begin
          state_d = S_FIX;
        end else begin
          mrem_d = mrem_q >> UNROLL;
        end
`endif
      end

      S_FIX: begin
        long_s = (op_q == OP_UMULL) || (op_q == OP_SMULL);
        case (kind_q)
          K_DIV0: begin
            res_lo_s = ZERO_W;
            res_hi_s = q_q;
          end
          K_ILL: begin
            res_lo_s = ZERO_W;
            res_hi_s = ZERO_W;
          end
          default: begin
            case (op_q)
              OP_MUL: begin
                res_lo_s = prod_s[WIDTH-1:0];
                res_hi_s = ZERO_W;
              end
              OP_UMULL, OP_SMULL: begin
                res_lo_s = prod_neg_s[WIDTH-1:0];
                res_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
              end
              OP_UDIV, OP_SDIV: begin
                // Quotient truncates toward zero; remainder follows the dividend.
                res_lo_s = qneg_q ? (ZERO_W - q_q) : q_q;
                res_hi_s = rneg_q ? (ZERO_W - acc_q) : acc_q;
              end
              default: begin
                res_lo_s = ZERO_W;
                res_hi_s = ZERO_W;
              end
            endcase
          end
        endcase
        flags_d = 4'b0000;
        if (kind_q != K_ILL) begin
          flags_d[FLAG_N] = long_s ? res_hi_s[WIDTH-1] : res_lo_s[WIDTH-1];
          flags_d[FLAG_Z] = long_s ? ({res_hi_s, res_lo_s} == {(2*WIDTH){1'b0}})
                                   : (res_lo_s == ZERO_W);
          flags_d[FLAG_C] = 1'b0;
          flags_d[FLAG_V] = ovf_q && (kind_q == K_NORM);
        end else begin
          flags_d = 4'b0000;
        end
        lo_d    = res_lo_s;
        hi_d    = res_hi_s;
        dbz_d   = (kind_q == K_DIV0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_NORM;
      op_q    <= 3'b000;
      acc_q   <= ZERO_W;
      q_q     <= ZERO_W;
      dv_q    <= ZERO_W;
      cnt_q   <= {CW{1'b0}};
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= ZERO_W;
      hi_q    <= ZERO_W;
      flags_q <= 4'b0000;
      dbz_q   <= 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
      mrem_q  <= ZERO_W;
`endif
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      dbz_q   <= dbz_d;
`ifdef MULDIV_EARLY_TERM_EN
      mrem_q  <= mrem_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign flags       = flags_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mc_muldiv_unit.sv
// Directed bench for mc_muldiv_unit at WIDTH=32, UNROLL=1.
// Latency is counted with the start-sampling cycle as cycle 0.
module tb_mc_muldiv_unit;

  localparam logic [2:0] T_MUL   = 3'b000;
  localparam logic [2:0] T_UMULL = 3'b001;
  localparam logic [2:0] T_SMULL = 3'b010;
  localparam logic [2:0] T_UDIV  = 3'b100;
  localparam logic [2:0] T_SDIV  = 3'b101;
  localparam logic [2:0] T_ILL   = 3'b011;

`ifdef MULDIV_EARLY_TERM_EN
  localparam int LAT_B1 = 3;
  localparam int LAT_B5 = 5;
`else
  localparam int LAT_B1 = 34;
  localparam int LAT_B5 = 34;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [3:0]  flags;
  logic        div_by_zero;

  int nvec;
  int nerr;
  int lat;
  logic seen_done;

  mc_muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .flags       (flags),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle; start is sampled on the next edge (cycle 0).
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int latv);
    latv = lat0;
    while (done !== 1'b1 && latv < 200) begin
      @(posedge clk);
      #1;
      latv++;
    end
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = 32'h0;
    b     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_res", {result_hi, result_lo}, 64'h0);
    check("rst_flags", {60'h0, flags}, 64'h0);
    check("rst_dbz", {63'h0, div_by_zero}, 64'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // UMULL max * max
    launch(T_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("umull_busy", {63'h0, busy}, 64'h1);
    wait_done(1, lat);
    check("umull_lat", 64'(lat), 64'd34);
    check("umull_res", {result_hi, result_lo}, 64'hFFFFFFFE_00000001);
    check("umull_flags", {60'h0, flags}, 64'b1000);
    check("umull_busy_done", {63'h0, busy}, 64'h0);
    @(posedge clk);
    #1;
    check("umull_done_pulse", {63'h0, done}, 64'h0);
    check("umull_hold", {result_hi, result_lo}, 64'hFFFFFFFE_00000001);

    // SMULL -3 * 7, then MUL overflowing to zero
    launch(T_SMULL, 32'hFFFFFFFD, 32'd7);
    wait_done(1, lat);
    check("smull_res", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFEB);
    check("smull_flags", {60'h0, flags}, 64'b1000);
    launch(T_MUL, 32'h00010000, 32'h00010000);
    wait_done(1, lat);
    check("mul_res", {result_hi, result_lo}, 64'h0);
    check("mul_flags", {60'h0, flags}, 64'b0100);

    // SDIV -7 / 2 and UDIV 100 / 7
    launch(T_SDIV, 32'hFFFFFFF9, 32'd2);
    wait_done(1, lat);
    check("sdiv_lat", 64'(lat), 64'd34);
    check("sdiv_res", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFFD);
    check("sdiv_flags", {60'h0, flags}, 64'b1000);
    launch(T_UDIV, 32'd100, 32'd7);
    wait_done(1, lat);
    check("udiv_res", {result_hi, result_lo}, {32'd2, 32'd14});
    check("udiv_flags", {60'h0, flags}, 64'b0000);

    // Divide by zero, then a normal divide clears the sticky bit
    launch(T_UDIV, 32'd100, 32'd0);
    wait_done(1, lat);
    check("dbz_lat", 64'(lat), 64'd2);
    check("dbz_res", {result_hi, result_lo}, {32'd100, 32'd0});
    check("dbz_flag", {63'h0, div_by_zero}, 64'h1);
    check("dbz_flags", {60'h0, flags}, 64'b0100);
    repeat (2) @(posedge clk);
    #1;
    check("dbz_sticky", {63'h0, div_by_zero}, 64'h1);
    launch(T_UDIV, 32'd9, 32'd3);
    wait_done(1, lat);
    check("udiv9_res", {result_hi, result_lo}, {32'd0, 32'd3});
    check("udiv9_dbz", {63'h0, div_by_zero}, 64'h0);

    // Illegal op
    launch(T_ILL, 32'h12345678, 32'h9ABCDEF0);
    wait_done(1, lat);
    check("ill_lat", 64'(lat), 64'd2);
    check("ill_res", {result_hi, result_lo}, 64'h0);
    check("ill_flags", {60'h0, flags}, 64'b0000);
    check("ill_dbz", {63'h0, div_by_zero}, 64'h0);

    // SDIV overflow with an ignored start at cycle 5
    launch(T_SDIV, 32'h80000000, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op    = T_UDIV;
    a     = 32'd5;
    b     = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, lat);
    check("ovf_lat", 64'(lat), 64'd34);
    check("ovf_res", {result_hi, result_lo}, 64'h00000000_80000000);
    check("ovf_flags", {60'h0, flags}, 64'b1001);
    check("ovf_dbz", {63'h0, div_by_zero}, 64'h0);

    // Back-to-back launch in the done cycle
    launch(T_UMULL, 32'd3, 32'd5);
    check("b2b_busy", {63'h0, busy}, 64'h1);
    check("b2b_done_low", {63'h0, done}, 64'h0);
    wait_done(1, lat);
    check("b2b_lat", 64'(lat), 64'(LAT_B5));
    check("b2b_res", {result_hi, result_lo}, 64'd15);
    check("b2b_flags", {60'h0, flags}, 64'b0000);

    // Early-termination case (fixed latency without the feature)
    launch(T_UMULL, 32'h12345678, 32'd1);
    wait_done(1, lat);
    check("b1_lat", 64'(lat), 64'(LAT_B1));
    check("b1_res", {result_hi, result_lo}, 64'h00000000_12345678);

    // Reset at cycle 10 of a UDIV
    launch(T_UDIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mrst_busy", {63'h0, busy}, 64'h0);
    check("mrst_res", {result_hi, result_lo}, 64'h0);
    check("mrst_flags", {60'h0, flags}, 64'h0);
    check("mrst_done", {63'h0, done}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("mrst_no_done", {63'h0, seen_done}, 64'h0);
    check("mrst_idle", {63'h0, busy}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
